// File: rtl/alarm_clock_core_if.sv
// Alarm clock core bus: BCD load inputs, controls and time/alarm outputs.
interface alarm_clock_core_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       STOP_al;
  logic       AL_ON;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [3:0] M_out1;
  logic [3:0] M_out0;
  logic [3:0] S_out1;
  logic [3:0] S_out0;
  logic       Alarm;

  modport master (
    output H_in1, H_in0, M_in1, M_in0,
    output LD_time, LD_alarm, STOP_al, AL_ON,
    input  H_out1, H_out0, M_out1, M_out0,
    input  S_out1, S_out0, Alarm
  );

  modport slave (
    input  H_in1, H_in0, M_in1, M_in0,
    input  LD_time, LD_alarm, STOP_al, AL_ON,
    output H_out1, H_out0, M_out1, M_out0,
    output S_out1, S_out0, Alarm
  );
endinterface

// File: rtl/alarm_clock_core.sv
// BCD 24h clock with 10 Hz prescaler, loadable time/alarm
// and a two-state ringing FSM with auto-timeout.
module alarm_clock_core (
  input logic              clk,
  input logic              reset,
  alarm_clock_core_if.slave bus
);
  typedef enum logic {IDLE, RINGING} state_t;

  state_t     state_q;
  logic       alarm_q;
  logic [5:0] ring_q;
  logic [3:0] pre_q;
  logic [1:0] h1_q, h1_d;
  logic [3:0] h0_q, h0_d;
  logic [3:0] m1_q, m1_d;
  logic [3:0] m0_q, m0_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s0_q, s0_d;
  logic [1:0] ah1_q;
  logic [3:0] ah0_q;
  logic [3:0] am1_q;
  logic [3:0] am0_q;

  logic tick;
  logic hr_ok;
  logic valid;
  logic ld_t;
  logic ld_a;
  logic hit;

  assign tick  = (pre_q == 4'd9);
  assign hr_ok = (bus.H_in1 < 2'd2) ? (bus.H_in0 <= 4'd9)
               : (bus.H_in1 == 2'd2) && (bus.H_in0 <= 4'd3);
  assign valid = hr_ok && (bus.M_in1 <= 4'd5)
               && (bus.M_in0 <= 4'd9);
  assign ld_t  = bus.LD_time && valid;
  assign ld_a  = bus.LD_alarm && valid;

  always_comb begin
    h1_d = h1_q;
    h0_d = h0_q;
    m1_d = m1_q;
    m0_d = m0_q;
    s1_d = s1_q;
    s0_d = s0_q;
    if (tick) begin
      if (s0_q != 4'd9) begin
        s0_d = s0_q + 4'd1;
      end else begin
        s0_d = 4'd0;
        if (s1_q != 4'd5) begin
          s1_d = s1_q + 4'd1;
        end else begin
          s1_d = 4'd0;
          if (m0_q != 4'd9) begin
            m0_d = m0_q + 4'd1;
          end else begin
            m0_d = 4'd0;
            if (m1_q != 4'd5) begin
              m1_d = m1_q + 4'd1;
            end else begin
              m1_d = 4'd0;
              if (h1_q == 2'd2 && h0_q == 4'd3) begin
                h1_d = 2'd0;
                h0_d = 4'd0;
              end else if (h0_q == 4'd9) begin
                h1_d = h1_q + 2'd1;
                h0_d = 4'd0;
              end else begin
                h0_d = h0_q + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Trigger only from a counted tick, against the stored alarm.
  assign hit = tick && !ld_t && bus.AL_ON && !bus.STOP_al
            && s1_d == 4'd0 && s0_d == 4'd0
            && h1_d == ah1_q && h0_d == ah0_q
            && m1_d == am1_q && m0_d == am0_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= 4'd0;
      h1_q  <= 2'd0;
      h0_q  <= 4'd0;
      m1_q  <= 4'd0;
      m0_q  <= 4'd0;
      s1_q  <= 4'd0;
      s0_q  <= 4'd0;
    end else if (ld_t) begin
      pre_q <= 4'd0;
      h1_q  <= bus.H_in1;
      h0_q  <= bus.H_in0;
      m1_q  <= bus.M_in1;
      m0_q  <= bus.M_in0;
      s1_q  <= 4'd0;
      s0_q  <= 4'd0;
    end else begin
      pre_q <= tick ? 4'd0 : pre_q + 4'd1;
      h1_q  <= h1_d;
      h0_q  <= h0_d;
      m1_q  <= m1_d;
      m0_q  <= m0_d;
      s1_q  <= s1_d;
      s0_q  <= s0_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ah1_q <= 2'd0;
      ah0_q <= 4'd0;
      am1_q <= 4'd0;
      am0_q <= 4'd0;
    end else if (ld_a) begin
      ah1_q <= bus.H_in1;
      ah0_q <= bus.H_in0;
      am1_q <= bus.M_in1;
      am0_q <= bus.M_in0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      alarm_q <= 1'b0;
      ring_q  <= 6'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= RINGING;
            alarm_q <= 1'b1;
            ring_q  <= 6'd0;
          end
        end
        RINGING: begin
          if (bus.STOP_al || !bus.AL_ON) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
          end else if (tick) begin
            if (ring_q == 6'd59) begin
              state_q <= IDLE;
              alarm_q <= 1'b0;
            end else begin
              ring_q <= ring_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.H_out1 = h1_q;
  assign bus.H_out0 = h0_q;
  assign bus.M_out1 = m1_q;
  assign bus.M_out0 = m0_q;
  assign bus.S_out1 = s1_q;
  assign bus.S_out0 = s0_q;
  assign bus.Alarm  = alarm_q;
endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed bench for alarm_clock_core: counting, loads,
// alarm trigger/stop/timeout and reset override.
module tb_alarm_clock_core;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   bad;

  alarm_clock_core_if bus ();

  alarm_clock_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] now();
    return {2'b00, bus.H_out1, bus.H_out0,
            bus.M_out1, bus.M_out0,
            bus.S_out1, bus.S_out0};
  endfunction

  function automatic logic bcd_bad();
    logic [7:0] hh;
    hh = {2'b00, bus.H_out1, bus.H_out0};
    return bus.S_out0 > 4'd9 || bus.S_out1 > 4'd5
        || bus.M_out0 > 4'd9 || bus.M_out1 > 4'd5
        || bus.H_out0 > 4'd9 || hh > 8'h23;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic t, input logic a,
                      input logic [1:0] h1,
                      input logic [3:0] h0,
                      input logic [3:0] m1,
                      input logic [3:0] m0);
    bus.H_in1    = h1;
    bus.H_in0    = h0;
    bus.M_in1    = m1;
    bus.M_in0    = m0;
    bus.LD_time  = t;
    bus.LD_alarm = a;
    step(1);
    bus.LD_time  = 1'b0;
    bus.LD_alarm = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.H_in1 = '0;
    bus.H_in0 = '0;
    bus.M_in1 = '0;
    bus.M_in0 = '0;
    bus.LD_time  = 1'b0;
    bus.LD_alarm = 1'b0;
    bus.STOP_al  = 1'b0;
    bus.AL_ON    = 1'b0;
    step(2);
    chk("rst_time", now(), 24'h000000);
    chk("rst_alarm", bus.Alarm, 1'b0);
    reset = 1'b0;

    step(9);
    chk("sec_c9", now(), 24'h000000);
    step(1);
    chk("sec_c10", now(), 24'h000001);
    step(590);
    chk("min_c600", now(), 24'h000100);

    load(1, 0, 2'd2, 4'd3, 4'd5, 4'd9);
    chk("ld_2359", now(), 24'h235900);
    bad = 0;
    for (int i = 0; i < 590; i++) begin
      step(1);
      if (bcd_bad()) bad++;
    end
    chk("t_235959", now(), 24'h235959);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bcd_bad()) bad++;
    end
    chk("wrap_000000", now(), 24'h000000);
    chk("bcd_range", bad, 0);

    load(1, 0, 2'd2, 4'd4, 4'd3, 4'd0);
    chk("ld_bad_hr", now(), 24'h000000);
    load(1, 0, 2'd1, 4'd2, 4'd6, 4'd0);
    chk("ld_bad_min", now(), 24'h000000);
    step(7);
    load(1, 0, 2'd1, 4'd2, 4'd3, 4'd4);
    chk("ld_vs_tick", now(), 24'h123400);
    step(9);
    chk("pre_rst9", now(), 24'h123400);
    step(1);
    chk("pre_rst10", now(), 24'h123401);

    bus.AL_ON = 1'b1;
    load(1, 1, 2'd0, 4'd7, 4'd0, 4'd0);
    chk("ld_both", now(), 24'h070000);
    step(20);
    chk("no_ring_ld", bus.Alarm, 1'b0);

    load(1, 0, 2'd0, 4'd6, 4'd5, 4'd9);
    step(599);
    chk("pre_trig_t", now(), 24'h065959);
    chk("pre_trig_a", bus.Alarm, 1'b0);
    step(1);
    chk("trig_t", now(), 24'h070000);
    chk("trig_a", bus.Alarm, 1'b1);
    step(5);
    bus.STOP_al = 1'b1;
    step(1);
    bus.STOP_al = 1'b0;
    chk("stop", bus.Alarm, 1'b0);

    load(1, 0, 2'd0, 4'd6, 4'd5, 4'd9);
    step(600);
    chk("ring2", bus.Alarm, 1'b1);
    step(599);
    chk("ring_59t", bus.Alarm, 1'b1);
    step(1);
    chk("ring_60t", bus.Alarm, 1'b0);

    bus.AL_ON = 1'b0;
    load(1, 0, 2'd0, 4'd6, 4'd5, 4'd9);
    step(600);
    chk("off_t", now(), 24'h070000);
    chk("off_a", bus.Alarm, 1'b0);

    bus.AL_ON = 1'b1;
    load(1, 0, 2'd0, 4'd6, 4'd5, 4'd9);
    step(599);
    bus.STOP_al = 1'b1;
    step(1);
    bus.STOP_al = 1'b0;
    chk("stop_win", bus.Alarm, 1'b0);
    step(1);
    chk("stop_win2", bus.Alarm, 1'b0);

    load(1, 0, 2'd0, 4'd6, 4'd5, 4'd9);
    step(600);
    chk("ring3", bus.Alarm, 1'b1);
    load(0, 1, 2'd0, 4'd8, 4'd0, 4'd0);
    chk("ld_in_ring", bus.Alarm, 1'b1);
    load(1, 0, 2'd1, 4'd0, 4'd0, 4'd0);
    chk("ldt_in_ring", bus.Alarm, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_ring_a", bus.Alarm, 1'b0);
    chk("rst_ring_t", now(), 24'h000000);

    load(1, 0, 2'd2, 4'd3, 4'd5, 4'd9);
    step(600);
    chk("al_rst_t", now(), 24'h000000);
    chk("al_rst_a", bus.Alarm, 1'b1);
    bus.AL_ON = 1'b0;
    step(1);
    chk("al_off", bus.Alarm, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
